branch_resolve: RTL and testbench

Resolves conditional branches and jumps one stage after the comparison unit: consumes its single-bit condition result together with the decoded control-flow operation, computes the link value and target, and drives a held redirect request to fetch. Registered output stage with valid/ready handshakes on both the result path (to writeback) and the redirect path (to fetch), plus free-running branch statistics counters.

---
 rtl/branch_resolve.sv | 168 ++++++++++++++++
 tb/tb_branch_resolve.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches and jumps one stage after the comparison
// unit. Computes the link value (pc+4), the control-transfer target and a misalignment
// flag, then holds a result for writeback and a redirect request for fetch.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      upstream handshake for one control-flow op
//   in_pc, in_imm, in_rs1    op PC, sign-extended immediate, rs1 value (JALR base)
//   in_is_branch/jal/jalr    op class, at most one set; none set = non-control op
//   cmp_out                  comparison result for a conditional branch
//   out_valid / out_ready    writeback handshake
//   out_rd_data              link value pc+4
//   out_taken                control transfer taken
//   out_misaligned           taken target not 4-byte aligned
//   redirect_valid / _ready  fetch redirect handshake
//   redirect_pc              redirect target
//   branch_count             accepted conditional branches (wraps)
//   taken_count              accepted taken transfers, misaligned included (wraps)
module branch_resolve #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic             cmp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rd_data,
  output logic             out_taken,
  output logic             out_misaligned,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      branch_count,
  output logic [31:0]      taken_count
);

  // The result and redirect registers are independent; the state encodes both.
  typedef enum logic [1:0] {StIdle, StRes, StRed, StResRed} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] rd_data_q;
  logic             taken_q;
  logic             misaligned_q;
  logic [WIDTH-1:0] redirect_pc_q;
  logic [31:0]      branch_count_q;
  logic [31:0]      taken_count_q;

  logic             accept;
  logic             taken;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] jalr_sum;
  logic             misaligned;
  logic             raise_redirect;
  logic             res_next;
  logic             red_next;

  // Datapath for the op being offered this cycle.
  always_comb begin
    jalr_sum = in_rs1 + in_imm;
    if (in_is_jalr) begin
      target = {jalr_sum[WIDTH-1:1], 1'b0};
    end else begin
      target = in_pc + in_imm;
    end
    taken          = in_is_jal | in_is_jalr | (in_is_branch & cmp_out);
    misaligned     = taken & target[1];
    // in_ready depends only on registered state and out_ready, never on in_valid.
    in_ready       = (!out_valid || out_ready) && !redirect_valid;
    accept         = in_valid && in_ready;
    // Misaligned targets trap downstream instead of redirecting fetch.
    raise_redirect = accept && taken && !misaligned;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each held register is set on its load event, otherwise kept until
  // its consumer is ready.
  always_comb begin
    res_next = out_valid && !out_ready;
    red_next = redirect_valid && !redirect_ready;
    if (accept) begin
      res_next = 1'b1;
    end
    if (raise_redirect) begin
      red_next = 1'b1;
    end
    unique case ({res_next, red_next})
      2'b00:   state_d = StIdle;
      2'b10:   state_d = StRes;
      2'b01:   state_d = StRed;
      default: state_d = StResRed;
    endcase
  end

  // Output decode from state.
  always_comb begin
    out_valid      = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StRes:    out_valid = 1'b1;
      StRed:    redirect_valid = 1'b1;
      StResRed: begin
        out_valid      = 1'b1;
        redirect_valid = 1'b1;
      end
      default:  ;
    endcase
  end

  // Payload registers load only on their event, so they stay stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      taken_q       <= 1'b0;
      misaligned_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      if (accept) begin
        rd_data_q    <= in_pc + WIDTH'(4);
        taken_q      <= taken;
        misaligned_q <= misaligned;
      end
      if (raise_redirect) begin
        redirect_pc_q <= target;
      end
    end
  end

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      if (accept && in_is_branch) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (accept && taken) begin
        taken_count_q <= taken_count_q + 32'd1;
      end
    end
  end

  assign out_rd_data    = rd_data_q;
  assign out_taken      = taken_q;
  assign out_misaligned = misaligned_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_count   = branch_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [31:0] in_rs1;
  logic        in_is_branch;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic        cmp_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd_data;
  logic        out_taken;
  logic        out_misaligned;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1        (in_rs1),
    .in_is_branch  (in_is_branch),
    .in_is_jal     (in_is_jal),
    .in_is_jalr    (in_is_jalr),
    .cmp_out       (cmp_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rd_data   (out_rd_data),
    .out_taken     (out_taken),
    .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc   (redirect_pc),
    .branch_count  (branch_count),
    .taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one op; kind: 0 none, 1 branch, 2 jal, 3 jalr.
  task automatic set_op(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input int kind, input logic cmp);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_imm       = imm;
    in_rs1       = rs1;
    in_is_branch = (kind == 1);
    in_is_jal    = (kind == 2);
    in_is_jalr   = (kind == 3);
    cmp_out      = cmp;
  endtask

  task automatic clear_op();
    in_valid     = 1'b0;
    in_is_branch = 1'b0;
    in_is_jal    = 1'b0;
    in_is_jalr   = 1'b0;
    cmp_out      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_ready = 1'b1;
    in_pc          = '0;
    in_imm         = '0;
    in_rs1         = '0;
    clear_op();
    #2;
    check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst rd_data", out_rd_data, 32'd0);
    check_eq("rst redirect_pc", redirect_pc, 32'd0);
    check_eq("rst branch_count", branch_count, 32'd0);
    check_eq("rst taken_count", taken_count, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    check_eq("idle in_ready", {31'd0, in_ready}, 32'd1);

    // BEQ taken
    set_op(32'h100, 32'h40, 32'h0, 1, 1'b1);
    tick();
    clear_op();
    check_eq("beq out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("beq rd_data", out_rd_data, 32'h104);
    check_eq("beq taken", {31'd0, out_taken}, 32'd1);
    check_eq("beq redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check_eq("beq redirect_pc", redirect_pc, 32'h140);
    check_eq("beq branch_count", branch_count, 32'd1);
    check_eq("beq taken_count", taken_count, 32'd1);
    check_eq("beq in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("beq drain redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("beq drain out", {31'd0, out_valid}, 32'd0);
    check_eq("beq drain in_ready", {31'd0, in_ready}, 32'd1);

    // BNE not-taken back-to-back stream
    for (int i = 0; i < 4; i++) begin
      set_op(32'h200 + 32'(i) * 4, 32'h20, 32'h0, 1, 1'b0);
      tick();
      check_eq("bne out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bne rd_data", out_rd_data, 32'h204 + 32'(i) * 4);
      check_eq("bne taken", {31'd0, out_taken}, 32'd0);
      check_eq("bne redirect", {31'd0, redirect_valid}, 32'd0);
      check_eq("bne in_ready", {31'd0, in_ready}, 32'd1);
    end
    clear_op();
    check_eq("bne branch_count", branch_count, 32'd5);
    check_eq("bne taken_count", taken_count, 32'd1);
    tick();

    // JALR clears bit 0 of the target
    set_op(32'h300, 32'h10, 32'h2001, 3, 1'b0);
    tick();
    clear_op();
    check_eq("jalr redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check_eq("jalr redirect_pc", redirect_pc, 32'h2010);
    check_eq("jalr misaligned", {31'd0, out_misaligned}, 32'd0);
    check_eq("jalr rd_data", out_rd_data, 32'h304);
    check_eq("jalr taken_count", taken_count, 32'd2);
    tick();

    // JAL to a misaligned target: no redirect, still counted as taken
    set_op(32'h100, 32'h6, 32'h0, 2, 1'b0);
    tick();
    clear_op();
    check_eq("jal_mis misaligned", {31'd0, out_misaligned}, 32'd1);
    check_eq("jal_mis taken", {31'd0, out_taken}, 32'd1);
    check_eq("jal_mis redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("jal_mis rd_data", out_rd_data, 32'h104);
    check_eq("jal_mis taken_count", taken_count, 32'd3);
    check_eq("jal_mis in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Backpressure on both paths
    out_ready      = 1'b0;
    redirect_ready = 1'b0;
    set_op(32'h400, 32'hFFFF_FFF8, 32'h0, 1, 1'b1);
    tick();
    // A younger op waits at the input and must not be taken in.
    set_op(32'h500, 32'h10, 32'h0, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check_eq("bp redirect_pc", redirect_pc, 32'h3F8);
      check_eq("bp out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp rd_data", out_rd_data, 32'h404);
      check_eq("bp in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    check_eq("bp red drop", {31'd0, redirect_valid}, 32'd0);
    check_eq("bp out held", {31'd0, out_valid}, 32'd1);
    check_eq("bp rd held", out_rd_data, 32'h404);
    check_eq("bp in_ready low", {31'd0, in_ready}, 32'd0);
    clear_op();
    out_ready = 1'b1;
    #1;
    check_eq("bp in_ready comb", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("bp out drained", {31'd0, out_valid}, 32'd0);
    check_eq("bp branch_count", branch_count, 32'd6);
    check_eq("bp taken_count", taken_count, 32'd4);

    // Address wrap
    set_op(32'hFFFF_FFFC, 32'h8, 32'h0, 2, 1'b0);
    tick();
    clear_op();
    check_eq("wrap rd_data", out_rd_data, 32'h0);
    check_eq("wrap redirect_pc", redirect_pc, 32'h4);
    check_eq("wrap redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check_eq("wrap taken_count", taken_count, 32'd5);
    tick();

    // Non-control op passes through
    set_op(32'h600, 32'h40, 32'h0, 0, 1'b1);
    tick();
    clear_op();
    check_eq("nop taken", {31'd0, out_taken}, 32'd0);
    check_eq("nop redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("nop rd_data", out_rd_data, 32'h604);
    check_eq("nop branch_count", branch_count, 32'd6);
    check_eq("nop taken_count", taken_count, 32'd5);
    tick();

    // Counter wrap from a preloaded all-ones value
    force dut.branch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    #1;
    check_eq("cnt preload", branch_count, 32'hFFFF_FFFF);
    set_op(32'h700, 32'h8, 32'h0, 1, 1'b0);
    tick();
    clear_op();
    check_eq("cnt wrap", branch_count, 32'd0);
    check_eq("cnt taken unchanged", taken_count, 32'd5);
    tick();

    // Asynchronous reset with both registers held
    out_ready      = 1'b0;
    redirect_ready = 1'b0;
    set_op(32'h800, 32'h10, 32'h0, 2, 1'b0);
    tick();
    clear_op();
    check_eq("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("pre-rst redirect_valid", {31'd0, redirect_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_eq("arst taken", {31'd0, out_taken}, 32'd0);
    check_eq("arst rd_data", out_rd_data, 32'd0);
    check_eq("arst redirect_pc", redirect_pc, 32'd0);
    check_eq("arst branch_count", branch_count, 32'd0);
    check_eq("arst taken_count", taken_count, 32'd0);
    #5;
    rst_n          = 1'b1;
    out_ready      = 1'b1;
    redirect_ready = 1'b1;
    tick();
    check_eq("post-rst idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
